// File: rtl/smartcargo_cmd_pkg.sv
// Shared command codes, FSM states and serial byte layout for the SmartCargo command controller.
// Purely declarative: no logic, no latency, no backpressure.
package smartcargo_cmd_pkg;

  localparam logic [1:0] CMD_NENHUM  = 2'b00;
  localparam logic [1:0] CMD_INICIAR = 2'b01;
  localparam logic [1:0] CMD_RESET   = 2'b10;
  localparam logic [1:0] CMD_EMERG   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EMERG = 2'd2
  } estado_t;

  localparam int BIT_CTRL = 7;
  localparam int BIT_INI  = 0;
  localparam int BIT_RST  = 2;
  localparam int BIT_EMG  = 4;

  // Index of each request inside the pending/source flag vectors.
  localparam int F_INI = 0;
  localparam int F_RST = 1;
  localparam int F_EMG = 2;

  localparam logic [3:0] REJ_MAX = 4'd15;

  function automatic logic [2:0] mascara_cmd(input logic [1:0] code);
    logic [2:0] m;
    m = 3'b000;
    case (code)
      CMD_INICIAR: m[F_INI] = 1'b1;
      CMD_RESET:   m[F_RST] = 1'b1;
      CMD_EMERG:   m[F_EMG] = 1'b1;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/temporizador_ack.sv
// Ack watchdog: counts enabled cycles, expirou high on the TIMEOUT_CYCLES-th one; limpar restarts it.
// Registered count, combinational expire; no backpressure.
module temporizador_ack #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpar,
  input  logic habilitar,
  output logic expirou
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpar) begin
      contagem <= '0;
    end else if (habilitar) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign expirou = habilitar && (contagem == ULTIMO);

endmodule

// File: rtl/controlador_comandos.sv
// Arbitrates serial/button requests into one command at a time (emergencia > reset > iniciar), valid/ack to main FSM.
// Request edge k -> cmd_valid after k+1; holds until ack; CMD_TIMEOUT_EN adds an ack watchdog with auto-retry.
module controlador_comandos
  import smartcargo_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_pronto,
  input  logic [7:0] dados_serial,
  input  logic       botao_iniciar,
  input  logic       botao_reset,
  input  logic       botao_emergencia,
  input  logic       fim_emergencia,
  input  logic       ack,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       origem_serial,
  output logic       emergencia_ativa,
  output logic [3:0] rejeitados,
  output logic       erro_timeout
);

  estado_t    estado, estado_nxt;
  logic [2:0] pend, pend_nxt, src, src_nxt;
  logic [2:0] req, req_ser, mask_ack;
  logic       ser_ok, rejeita, ack_ok, preempt, expira, timeout_ok;
  logic       ini_preemptado;
  logic       valid_nxt, orig_nxt;
  logic [1:0] code_nxt;
  logic       unused_bits;

  assign ser_ok  = serial_pronto && dados_serial[BIT_CTRL] &&
                   (dados_serial[BIT_INI] || dados_serial[BIT_RST] || dados_serial[BIT_EMG]);
  assign rejeita = serial_pronto && !ser_ok;
  assign req_ser = ser_ok ? {dados_serial[BIT_EMG], dados_serial[BIT_RST], dados_serial[BIT_INI]} : 3'b000;
  assign req     = req_ser | {botao_emergencia, botao_reset, botao_iniciar};
  assign unused_bits = ^{dados_serial[6:5], dados_serial[3], dados_serial[1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt = estado;
    valid_nxt  = 1'b0;
    code_nxt   = CMD_NENHUM;
    orig_nxt   = 1'b0;
    ack_ok     = 1'b0;
    preempt    = 1'b0;
    timeout_ok = 1'b0;
    case (estado)
      IDLE: begin
        if (|pend) begin
          estado_nxt = ISSUE;
          valid_nxt  = 1'b1;
          if (pend[F_EMG]) begin
            code_nxt = CMD_EMERG;
            orig_nxt = src[F_EMG];
          end else if (pend[F_RST]) begin
            code_nxt = CMD_RESET;
            orig_nxt = src[F_RST];
          end else begin
            code_nxt = CMD_INICIAR;
            orig_nxt = src[F_INI];
          end
        end
      end
      ISSUE: begin
        if (ack) begin
          ack_ok     = 1'b1;
          estado_nxt = (cmd_code == CMD_EMERG) ? EMERG : IDLE;
        end else if (pend[F_EMG] && cmd_code != CMD_EMERG) begin
          preempt   = 1'b1;
          valid_nxt = 1'b1;
          code_nxt  = CMD_EMERG;
          orig_nxt  = src[F_EMG];
        end else if (expira) begin
          timeout_ok = 1'b1;
          estado_nxt = IDLE;
        end else begin
          valid_nxt = 1'b1;
          code_nxt  = cmd_code;
          orig_nxt  = origem_serial;
        end
      end
      EMERG: begin
        if (fim_emergencia) estado_nxt = IDLE;
      end
      default: estado_nxt = IDLE;
    endcase
  end

  // A same-cycle request re-sets the flag its ack clears; during EMERG only a preempted iniciar survives.
  assign mask_ack = ack_ok ? mascara_cmd(cmd_code) : 3'b000;

  always_comb begin
    pend_nxt = (pend & ~mask_ack) | req;
    src_nxt  = (src & ~mask_ack) | req_ser;
    if (estado == EMERG) begin
      pend_nxt[F_INI] = pend[F_INI] && ini_preemptado;
      src_nxt[F_INI]  = src[F_INI] && ini_preemptado;
      pend_nxt[F_EMG] = 1'b0;
      src_nxt[F_EMG]  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend             <= '0;
      src              <= '0;
      ini_preemptado   <= 1'b0;
      cmd_valid        <= 1'b0;
      cmd_code         <= CMD_NENHUM;
      origem_serial    <= 1'b0;
      emergencia_ativa <= 1'b0;
      rejeitados       <= '0;
    end else begin
      pend             <= pend_nxt;
      src              <= src_nxt;
      cmd_valid        <= valid_nxt;
      cmd_code         <= code_nxt;
      origem_serial    <= orig_nxt;
      emergencia_ativa <= (estado_nxt == EMERG);
      if (preempt && cmd_code == CMD_INICIAR) ini_preemptado <= 1'b1;
      else if (estado == EMERG && fim_emergencia) ini_preemptado <= 1'b0;
      if (rejeita && rejeitados != REJ_MAX) rejeitados <= rejeitados + 4'd1;
    end
  end

`ifdef CMD_TIMEOUT_EN
  logic tmr_limpar;
  assign tmr_limpar = (estado != ISSUE) || preempt;

  temporizador_ack #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_temporizador_ack (
    .clock    (clock),
    .reset    (reset),
    .limpar   (tmr_limpar),
    .habilitar(estado == ISSUE),
    .expirou  (expira)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          erro_timeout <= 1'b0;
    else if (timeout_ok) erro_timeout <= 1'b1;
    else if (ack_ok)     erro_timeout <= 1'b0;
  end
`else
  logic unused_cfg;
  assign expira       = 1'b0;
  assign erro_timeout = 1'b0;
  assign unused_cfg   = timeout_ok ^ (TIMEOUT_CYCLES < 2);
`endif

endmodule

// File: tb/tb_controlador_comandos.sv
// Directed bench for controlador_comandos; timeout scenario selected by CMD_TIMEOUT_EN.
module tb_controlador_comandos;

  logic       clock;
  logic       reset;
  logic       serial_pronto;
  logic [7:0] dados_serial;
  logic       botao_iniciar, botao_reset, botao_emergencia;
  logic       fim_emergencia, ack;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       origem_serial, emergencia_ativa, erro_timeout;
  logic [3:0] rejeitados;

  int n_checks = 0;
  int n_erros  = 0;

  controlador_comandos #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .serial_pronto   (serial_pronto),
    .dados_serial    (dados_serial),
    .botao_iniciar   (botao_iniciar),
    .botao_reset     (botao_reset),
    .botao_emergencia(botao_emergencia),
    .fim_emergencia  (fim_emergencia),
    .ack             (ack),
    .cmd_valid       (cmd_valid),
    .cmd_code        (cmd_code),
    .origem_serial   (origem_serial),
    .emergencia_ativa(emergencia_ativa),
    .rejeitados      (rejeitados),
    .erro_timeout    (erro_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic confere(input string tag, input int v, input int c, input int o);
    verifica({tag, " valid"}, 32'(cmd_valid), v);
    verifica({tag, " code"}, 32'(cmd_code), c);
    verifica({tag, " origem"}, 32'(origem_serial), o);
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic byte_serial(input logic [7:0] b);
    serial_pronto = 1'b1;
    dados_serial  = b;
    ciclo();
    serial_pronto = 1'b0;
    dados_serial  = 8'h00;
  endtask

  task automatic ack_pulso();
    ack = 1'b1;
    ciclo();
    ack = 1'b0;
  endtask

  task automatic fim_pulso();
    fim_emergencia = 1'b1;
    ciclo();
    fim_emergencia = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    serial_pronto = 1'b0; dados_serial = 8'h00;
    botao_iniciar = 1'b0; botao_reset = 1'b0; botao_emergencia = 1'b0;
    fim_emergencia = 1'b0; ack = 1'b0;

    ciclo();
    confere("reset", 0, 0, 0);
    verifica("reset emerg", 32'(emergencia_ativa), 0);
    verifica("reset rej", 32'(rejeitados), 0);
    verifica("reset erro", 32'(erro_timeout), 0);
    reset = 1'b1;
    ciclo();

    // Serial iniciar 0x81
    byte_serial(8'h81);
    confere("t1 pend", 0, 0, 0);
    ciclo();
    confere("t1 issue", 1, 1, 1);
    ack_pulso();
    confere("t1 ack", 0, 0, 0);
    ciclo();
    confere("t1 idle", 0, 0, 0);

    // All three bits: emergencia first, iniciar discarded in EMERG, reset survives
    byte_serial(8'h95);
    ciclo();
    confere("t2 emg", 1, 3, 1);
    ack_pulso();
    confere("t2 ack", 0, 0, 0);
    verifica("t2 emerg on", 32'(emergencia_ativa), 1);
    repeat (3) ciclo();
    confere("t2 hold", 0, 0, 0);
    fim_pulso();
    verifica("t2 emerg off", 32'(emergencia_ativa), 0);
    confere("t2 fim", 0, 0, 0);
    ciclo();
    confere("t2 rst", 1, 2, 1);
    ack_pulso();
    confere("t2 rst ack", 0, 0, 0);
    repeat (2) ciclo();
    confere("t2 no ini", 0, 0, 0);

    // Button iniciar preempted by button emergencia
    botao_iniciar = 1'b1;
    ciclo();
    botao_iniciar = 1'b0;
    ciclo();
    confere("t3 ini", 1, 1, 0);
    repeat (2) ciclo();
    confere("t3 held", 1, 1, 0);
    botao_emergencia = 1'b1;
    ciclo();
    botao_emergencia = 1'b0;
    confere("t3 pend emg", 1, 1, 0);
    ciclo();
    confere("t3 preempt", 1, 3, 0);
    ack_pulso();
    verifica("t3 emerg on", 32'(emergencia_ativa), 1);
    confere("t3 emg ack", 0, 0, 0);
    fim_pulso();
    ciclo();
    confere("t3 reissue", 1, 1, 0);
    ack_pulso();
    confere("t3 done", 0, 0, 0);

    // New request on the ack edge keeps the flag pending
    botao_iniciar = 1'b1;
    ciclo();
    botao_iniciar = 1'b0;
    ciclo();
    confere("t5 ini", 1, 1, 0);
    ack = 1'b1; botao_iniciar = 1'b1;
    ciclo();
    ack = 1'b0; botao_iniciar = 1'b0;
    confere("t5 ack", 0, 0, 0);
    ciclo();
    confere("t5 again", 1, 1, 0);
    ack_pulso();
    ciclo();
    confere("t5 idle", 0, 0, 0);

    // Rejected bytes saturate at 15
    for (int i = 0; i < 17; i++) begin
      byte_serial((i % 2 == 1) ? 8'h80 : 8'h01);
      verifica("t4 rej", 32'(rejeitados), (i + 1 > 15) ? 15 : i + 1);
    end
    ciclo();
    confere("t4 none", 0, 0, 0);

    // Unacked command: watchdog retry, or indefinite wait without it
    botao_iniciar = 1'b1;
    ciclo();
    botao_iniciar = 1'b0;
    ciclo();
    confere("t6 issue", 1, 1, 0);
`ifdef CMD_TIMEOUT_EN
    repeat (7) ciclo();
    confere("t6 still", 1, 1, 0);
    verifica("t6 erro pre", 32'(erro_timeout), 0);
    ciclo();
    confere("t6 drop", 0, 0, 0);
    verifica("t6 erro set", 32'(erro_timeout), 1);
    ciclo();
    confere("t6 retry", 1, 1, 0);
    verifica("t6 erro held", 32'(erro_timeout), 1);
    ack_pulso();
    verifica("t6 erro clr", 32'(erro_timeout), 0);
`else
    repeat (10) ciclo();
    confere("t6 wait", 1, 1, 0);
    verifica("t6 erro", 32'(erro_timeout), 0);
    ack_pulso();
    confere("t6 ack", 0, 0, 0);
`endif

    // Reset during ISSUE (rejeitados is still 15 here)
    botao_reset = 1'b1;
    ciclo();
    botao_reset = 1'b0;
    ciclo();
    confere("t7 issue", 1, 2, 0);
    #2 reset = 1'b0;
    #1;
    confere("t7 rst", 0, 0, 0);
    verifica("t7 rej", 32'(rejeitados), 0);
    #1 reset = 1'b1;
    repeat (2) ciclo();
    confere("t7 none", 0, 0, 0);

    // Reset during EMERG with a reset command still pending
    botao_emergencia = 1'b1; botao_reset = 1'b1;
    ciclo();
    botao_emergencia = 1'b0; botao_reset = 1'b0;
    ciclo();
    confere("t8 emg", 1, 3, 0);
    ack_pulso();
    verifica("t8 emerg on", 32'(emergencia_ativa), 1);
    #2 reset = 1'b0;
    #1;
    verifica("t8 emerg rst", 32'(emergencia_ativa), 0);
    confere("t8 rst", 0, 0, 0);
    #1 reset = 1'b1;
    repeat (3) ciclo();
    confere("t8 none", 0, 0, 0);
    verifica("t8 emerg idle", 32'(emergencia_ativa), 0);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule
